// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types and helpers for the phase test sequencer
package types_pkg;

    typedef logic [15:0] uword;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRST,
        S_RUN,
        S_CREQ,
        S_CWAIT,
        S_NEXT,
        S_DONE
    } test_seq_state_e;

    localparam logic [7:0] FAIL_MAX = 8'hFF;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == FAIL_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/phase_test_sequencer_if.sv
// rtl/phase_test_sequencer_if.sv - check-table and memory read port bundle
interface phase_test_sequencer_if
    import types_pkg::*;
#(
    parameter int CW = 5
);

    logic [CW-1:0] chk_idx;
    uword          chk_addr;
    uword          chk_exp;
    logic          rd_en;
    uword          rd_addr;
    uword          rd_data;

    modport master (
        output chk_idx,
        output rd_en,
        output rd_addr,
        input  chk_addr,
        input  chk_exp,
        input  rd_data
    );

    modport slave (
        input  chk_idx,
        input  rd_en,
        input  rd_addr,
        output chk_addr,
        output chk_exp,
        output rd_data
    );

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter, expire while the count is zero
module phase_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/phase_test_sequencer.sv
// rtl/phase_test_sequencer.sv - per-phase CPU reset, run window and memory checkpoint sequencer
module phase_test_sequencer
    import types_pkg::*;
#(
    parameter  int NUM_PHASES   = 16,
    parameter  int PHASE_CYCLES = 20,
    parameter  int RST_CYCLES   = 2,
    parameter  int NUM_CHECKS   = 2,
    parameter  int REQUIRE_HALT = 0,
    localparam int PW           = idx_width(NUM_PHASES),
    localparam int CW           = idx_width(NUM_PHASES * NUM_CHECKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt_sys,
    output logic                  cpu_rst,
    output logic [PW-1:0]         phase,
    phase_test_sequencer_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [7:0]            fail_count,
    output logic [PW-1:0]         first_fail_phase
);

    localparam int KW = idx_width(NUM_CHECKS);
    localparam int TW = idx_width((PHASE_CYCLES > RST_CYCLES) ? PHASE_CYCLES : RST_CYCLES);
    localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LOAD = TW'(PHASE_CYCLES - 1);

    test_seq_state_e state, state_next;
    logic [KW-1:0]   k;
    uword            exp_q;
    logic            tmr_load, tmr_en, tmr_expire;
    logic [TW-1:0]   tmr_val;
    logic            last_phase, last_check;
    logic            run_fail, chk_fail, fail_event;

    phase_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = RST_LOAD;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PRST;
                    tmr_load   = 1'b1;
                end
            end
            S_PRST: begin
                if (tmr_expire) begin
                    state_next = S_RUN;
                    tmr_load   = 1'b1;
                    tmr_val    = RUN_LOAD;
                end
            end
            // Halt wins over a simultaneous budget expiry.
            S_RUN:   if (halt_sys || tmr_expire) state_next = S_CREQ;
            S_CREQ:  state_next = S_CWAIT;
            S_CWAIT: state_next = last_check ? S_NEXT : S_CREQ;
            S_NEXT: begin
                if (last_phase) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_PRST;
                    tmr_load   = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign last_phase  = (phase == PW'(NUM_PHASES - 1));
    assign last_check  = (k == KW'(NUM_CHECKS - 1));
    assign tmr_en      = (state == S_PRST) || (state == S_RUN);
    assign cpu_rst     = rst || (state == S_PRST);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign mem.chk_idx = CW'(int'(phase) * NUM_CHECKS + int'(k));
    assign mem.rd_en   = (state == S_CREQ);
    assign mem.rd_addr = (state == S_CREQ) ? mem.chk_addr : '0;
    assign run_fail    = (REQUIRE_HALT != 0) && (state == S_RUN) && tmr_expire && !halt_sys;
    assign chk_fail    = (state == S_CWAIT) && (mem.rd_data != exp_q);
    assign fail_event  = run_fail || chk_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase            <= '0;
            k                <= '0;
            exp_q            <= '0;
            fail_count       <= '0;
            first_fail_phase <= '0;
            mismatch         <= 1'b0;
        end else begin
            mismatch <= chk_fail;
            if ((state == S_IDLE) && start) begin
                phase            <= '0;
                fail_count       <= '0;
                first_fail_phase <= '0;
            end else if (fail_event) begin
                fail_count <= sat_inc(fail_count);
                // fail_count saturates instead of wrapping, so zero marks the first failure.
                if (fail_count == '0) first_fail_phase <= phase;
            end
            if (state == S_RUN) k <= '0;
            if (state == S_CREQ) exp_q <= mem.chk_exp;
            if ((state == S_CWAIT) && !last_check) k <= k + 1'b1;
            if ((state == S_NEXT) && !last_phase) phase <= phase + 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_test_sequencer.sv
// tb/tb_phase_test_sequencer.sv - self-checking bench for phase_test_sequencer
module tb_phase_test_sequencer;
    import types_pkg::*;

    localparam int A_NP = 2;
    localparam int A_PC = 20;
    localparam int A_RC = 2;
    localparam int A_NC = 2;
    localparam int A_PW = idx_width(A_NP);
    localparam int A_CW = idx_width(A_NP * A_NC);
    localparam int B_NP = 16;
    localparam int B_PC = 8;
    localparam int B_RC = 3;
    localparam int B_NC = 16;
    localparam int B_PW = idx_width(B_NP);
    localparam int B_CW = idx_width(B_NP * B_NC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, halt_a = 1'b0, cpu_rst_a, busy_a, done_a, mismatch_a;
    logic [A_PW-1:0] phase_a, first_a;
    logic [7:0] fail_count_a;
    logic start_b = 1'b0, halt_b = 1'b0, cpu_rst_b, busy_b, done_b, mismatch_b;
    logic [B_PW-1:0] phase_b, first_b;
    logic [7:0] fail_count_b;

    phase_test_sequencer_if #(.CW(A_CW)) if_a ();
    phase_test_sequencer_if #(.CW(B_CW)) if_b ();

    phase_test_sequencer #(
        .NUM_PHASES(A_NP), .PHASE_CYCLES(A_PC), .RST_CYCLES(A_RC),
        .NUM_CHECKS(A_NC), .REQUIRE_HALT(0)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_a), .halt_sys(halt_a), .cpu_rst(cpu_rst_a),
        .phase(phase_a), .mem(if_a), .busy(busy_a), .done(done_a), .mismatch(mismatch_a),
        .fail_count(fail_count_a), .first_fail_phase(first_a)
    );

    phase_test_sequencer #(
        .NUM_PHASES(B_NP), .PHASE_CYCLES(B_PC), .RST_CYCLES(B_RC),
        .NUM_CHECKS(B_NC), .REQUIRE_HALT(1)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_b), .halt_sys(halt_b), .cpu_rst(cpu_rst_b),
        .phase(phase_b), .mem(if_b), .busy(busy_b), .done(done_b), .mismatch(mismatch_b),
        .fail_count(fail_count_b), .first_fail_phase(first_b)
    );

    uword tab_addr_a [A_NP*A_NC];
    uword tab_exp_a  [A_NP*A_NC];
    uword mem_a      [256];
    uword tab_addr_b [B_NP*B_NC];
    uword tab_exp_b  [B_NP*B_NC];
    uword mem_b      [256];

    assign if_a.chk_addr = tab_addr_a[if_a.chk_idx];
    assign if_a.chk_exp  = tab_exp_a[if_a.chk_idx];
    assign if_b.chk_addr = tab_addr_b[if_b.chk_idx];
    assign if_b.chk_exp  = tab_exp_b[if_b.chk_idx];

    always @(posedge clk) begin
        if (if_a.rd_en) if_a.rd_data <= mem_a[if_a.rd_addr[7:0]];
        if (if_b.rd_en) if_b.rd_data <= mem_b[if_b.rd_addr[7:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int h_a = 99;
    int h_b [B_NP];
    bit flip_b [B_NP*B_NC];
    int rc_a = 0, rc_b = 0;
    int cnt_busy_a = 0, cnt_done_a = 0, cnt_mm_a = 0, rl_a = 0, idx_a = 0;
    int cnt_busy_b = 0, cnt_done_b = 0, cnt_mm_b = 0;
    int rst_len_a [$];

    // halt_sys is raised during the h-th RUN cycle (0-based) counted from cpu_rst release.
    always @(negedge clk) begin
        if (cpu_rst_a) begin
            rc_a = 0; halt_a = 1'b0;
        end else begin
            halt_a = (rc_a == h_a); rc_a++;
        end
        if (cpu_rst_b) begin
            rc_b = 0; halt_b = 1'b0;
        end else begin
            halt_b = (rc_b == h_b[phase_b]); rc_b++;
        end
        if (busy_a) cnt_busy_a++;
        if (done_a) cnt_done_a++;
        if (mismatch_a) cnt_mm_a++;
        if (busy_b) cnt_busy_b++;
        if (done_b) cnt_done_b++;
        if (mismatch_b) cnt_mm_b++;
        if (cpu_rst_a) begin
            rl_a++;
        end else if (rl_a != 0) begin
            rst_len_a.push_back(rl_a);
            rl_a = 0;
        end
        if (if_a.rd_en) begin
            check("a_chk_idx_order", int'(if_a.chk_idx), idx_a);
            check("a_rd_addr", int'(if_a.rd_addr), int'(tab_addr_a[if_a.chk_idx]));
            idx_a++;
        end
    end

    typedef struct {
        int       halt_at;
        logic [3:0] flip;
        bit       restart;
        int       exp_fail;
        int       exp_first;
        int       exp_mm;
        int       exp_busy;
    } vec_a_t;

    vec_a_t va [5];

    task automatic run_a(input vec_a_t v, input int id);
        logic [3:0] fl;
        int t;
        fl = v.flip;
        for (int i = 0; i < A_NP*A_NC; i++)
            mem_a[tab_addr_a[i][7:0]] = tab_exp_a[i] ^ (fl[i] ? 16'h0001 : 16'h0000);
        h_a = v.halt_at;
        @(negedge clk); #2;
        cnt_busy_a = 0; cnt_done_a = 0; cnt_mm_a = 0; rl_a = 0; idx_a = 0;
        rst_len_a.delete();
        start_a = 1'b1;
        @(negedge clk); #2 start_a = 1'b0;
        if (v.restart) begin
            repeat (8) @(negedge clk);
            #2 start_a = 1'b1;
            @(negedge clk); #1;
            check($sformatf("a%0d_restart_phase", id), int'(phase_a), 0);
            check($sformatf("a%0d_restart_busy", id), int'(busy_a), 1);
            #1 start_a = 1'b0;
        end
        t = 0;
        while (cnt_done_a == 0 && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        check($sformatf("a%0d_done_within_bound", id), int'(t < 3000), 1);
        repeat (3) @(negedge clk);
        #1;
        check($sformatf("a%0d_fail_count", id), int'(fail_count_a), v.exp_fail);
        check($sformatf("a%0d_first_fail_phase", id), int'(first_a), v.exp_first);
        check($sformatf("a%0d_mismatch_pulses", id), cnt_mm_a, v.exp_mm);
        check($sformatf("a%0d_busy_cycles", id), cnt_busy_a, v.exp_busy);
        check($sformatf("a%0d_done_pulses", id), cnt_done_a, 1);
        check($sformatf("a%0d_idle_after", id), int'(busy_a), 0);
        check($sformatf("a%0d_checks_issued", id), idx_a, A_NP*A_NC);
        check($sformatf("a%0d_cpu_rst_count", id), rst_len_a.size(), A_NP);
        foreach (rst_len_a[i])
            check($sformatf("a%0d_cpu_rst_len", id), rst_len_a[i], A_RC);
    endtask

    task automatic run_b(input string tag);
        int f, mm, busy, first, t;
        bit pf;
        f = 0; mm = 0; busy = 1; first = -1;
        for (int p = 0; p < B_NP; p++) begin
            pf = 1'b0;
            if (h_b[p] >= B_PC) begin
                f++; pf = 1'b1; busy += B_PC;
            end else begin
                busy += h_b[p] + 1;
            end
            busy += B_RC + 2*B_NC + 1;
            for (int c = 0; c < B_NC; c++) begin
                if (flip_b[p*B_NC + c]) begin
                    f++; mm++; pf = 1'b1;
                end
            end
            if (pf && first < 0) first = p;
        end
        for (int i = 0; i < B_NP*B_NC; i++) begin
            uword m;
            m = flip_b[i] ? (16'h0001 << (i % 16)) : 16'h0000;
            mem_b[i] = tab_exp_b[i] ^ m;
        end
        @(negedge clk); #2;
        cnt_busy_b = 0; cnt_done_b = 0; cnt_mm_b = 0;
        start_b = 1'b1;
        @(negedge clk); #2 start_b = 1'b0;
        t = 0;
        while (cnt_done_b == 0 && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        check({tag, "_done_within_bound"}, int'(t < 3000), 1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_fail_count"}, int'(fail_count_b), (f > 255) ? 255 : f);
        check({tag, "_first_fail_phase"}, int'(first_b), (first < 0) ? 0 : first);
        check({tag, "_mismatch_pulses"}, cnt_mm_b, mm);
        check({tag, "_busy_cycles"}, cnt_busy_b, busy);
        check({tag, "_done_pulses"}, cnt_done_b, 1);
    endtask

    task automatic reset_mid_b();
        int t;
        for (int p = 0; p < B_NP; p++) h_b[p] = 99;
        for (int i = 0; i < B_NP*B_NC; i++) flip_b[i] = (i < B_NC);
        for (int i = 0; i < B_NP*B_NC; i++)
            mem_b[i] = tab_exp_b[i] ^ (flip_b[i] ? 16'h0100 : 16'h0000);
        @(negedge clk); #2;
        cnt_done_b = 0;
        start_b = 1'b1;
        @(negedge clk); #2 start_b = 1'b0;
        t = 0;
        while (!(phase_b == B_PW'(3) && !cpu_rst_b) && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        check("rstmid_reach_phase3_run", int'(t < 3000), 1);
        repeat (3) @(negedge clk);
        #1;
        // 16 phase-0 mismatches plus three unhalted run windows before phase 3.
        check("rstmid_fail_before_rst", int'(fail_count_b), 19);
        #1 rst = 1'b1;
        #1;
        check("rstmid_busy", int'(busy_b), 0);
        check("rstmid_phase", int'(phase_b), 0);
        check("rstmid_fail_count", int'(fail_count_b), 0);
        check("rstmid_first_fail", int'(first_b), 0);
        check("rstmid_cpu_rst", int'(cpu_rst_b), 1);
        check("rstmid_rd_en", int'(if_b.rd_en), 0);
        check("rstmid_done", int'(done_b), 0);
        check("rstmid_mismatch", int'(mismatch_b), 0);
        repeat (2) @(negedge clk);
        #1 check("rstmid_cpu_rst_held", int'(cpu_rst_b), 1);
        #1 rst = 1'b0;
        #1 check("rstmid_cpu_rst_release", int'(cpu_rst_b), 0);
        repeat (100) @(negedge clk);
        #1;
        check("rstmid_no_done", cnt_done_b, 0);
        check("rstmid_stays_idle", int'(busy_b), 0);
    endtask

    initial begin
        tab_addr_a[0] = 16'h0010; tab_exp_a[0] = 16'h1111;
        tab_addr_a[1] = 16'h0024; tab_exp_a[1] = 16'h1B2C;
        tab_addr_a[2] = 16'h0038; tab_exp_a[2] = 16'h2BCD;
        tab_addr_a[3] = 16'h004C; tab_exp_a[3] = 16'h3A5A;
        for (int i = 0; i < B_NP*B_NC; i++) begin
            tab_addr_b[i] = 16'hA500 | uword'(i);
            tab_exp_b[i]  = uword'($urandom);
        end
        for (int p = 0; p < B_NP; p++) h_b[p] = 99;

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", int'(busy_a), 0);
        check("reset_cpu_rst_held", int'(cpu_rst_a), 1);
        check("reset_done", int'(done_a), 0);
        check("reset_fail_count", int'(fail_count_b), 0);
        check("reset_rd_en", int'(if_b.rd_en), 0);
        check("reset_phase", int'(phase_b), 0);
        #1 rst = 1'b0;
        #1;
        check("reset_cpu_rst_release_a", int'(cpu_rst_a), 0);
        check("reset_cpu_rst_release_b", int'(cpu_rst_b), 0);

        va[0] = '{halt_at: 99, flip: 4'b0000, restart: 1'b1, exp_fail: 0, exp_first: 0, exp_mm: 0, exp_busy: 55};
        va[1] = '{halt_at: 5,  flip: 4'b0000, restart: 1'b0, exp_fail: 0, exp_first: 0, exp_mm: 0, exp_busy: 27};
        va[2] = '{halt_at: 99, flip: 4'b0100, restart: 1'b0, exp_fail: 1, exp_first: 1, exp_mm: 1, exp_busy: 55};
        va[3] = '{halt_at: 19, flip: 4'b1001, restart: 1'b0, exp_fail: 2, exp_first: 0, exp_mm: 2, exp_busy: 55};
        va[4] = '{halt_at: 0,  flip: 4'b1111, restart: 1'b0, exp_fail: 4, exp_first: 0, exp_mm: 4, exp_busy: 17};
        for (int i = 0; i < 5; i++) run_a(va[i], i);

        for (int p = 0; p < B_NP; p++) h_b[p] = 5;
        for (int i = 0; i < B_NP*B_NC; i++) flip_b[i] = 1'b0;
        run_b("b_halt5");
        check("b_halt5_no_timeout_fail", int'(fail_count_b), 0);

        for (int p = 0; p < B_NP; p++) h_b[p] = 99;
        for (int i = 0; i < B_NP*B_NC; i++) flip_b[i] = 1'b1;
        run_b("b_saturate");
        check("b_saturate_255", int'(fail_count_b), 255);
        check("b_saturate_pulses", cnt_mm_b, B_NP*B_NC);

        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < B_NP; p++) h_b[p] = int'($urandom_range(0, 10));
            for (int i = 0; i < B_NP*B_NC; i++) flip_b[i] = ($urandom_range(0, 19) == 0);
            run_b($sformatf("b_rand%0d", r));
        end

        reset_mid_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_test_sequencer.md
PHASE_TEST_SEQUENCER -- requirements
Module: phase_test_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 16: number of test phases run per start.
REQ-002 SHALL have parameter PHASE_CYCLES, default 20: cycle budget per phase RUN, counted from cpu_rst deassertion.
REQ-003 SHALL have parameter RST_CYCLES, default 2: cycles cpu_rst is held per phase.
REQ-004 SHALL have parameter NUM_CHECKS, default 2: memory checkpoints per phase.
REQ-005 SHALL have parameter REQUIRE_HALT, default 0: 1 = budget expiry without halt counts as one failure.
REQ-006 SHALL have ports clk input 1 (system clock) and rst input 1; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port start input 1: begin a full sequence when in IDLE.
REQ-008 SHALL have port halt_sys input 1: CPU halted.
REQ-009 SHALL have port cpu_rst output 1: reset to CPU under test.
REQ-010 SHALL have port phase output clog2(NUM_PHASES): current phase index.
REQ-011 SHALL have port chk_idx output clog2(NUM_PHASES*NUM_CHECKS): check-table index.
REQ-012 SHALL have ports chk_addr input 16 and chk_exp input 16 (uword): combinational table response to chk_idx.
REQ-013 SHALL have ports rd_en output 1, rd_addr output 16, rd_data input 16: memory read port, data valid exactly one cycle after rd_en.
REQ-014 SHALL have ports busy output 1, done output 1 (one-cycle pulse), mismatch output 1 (one-cycle pulse).
REQ-015 SHALL have ports fail_count output 8 and first_fail_phase output clog2(NUM_PHASES).

Function
REQ-016 SHALL implement states IDLE, PRST, RUN, CREQ, CWAIT, NEXT, DONE.
REQ-017 IDLE: start=1 -> PRST, phase=0, fail_count=0, first_fail_phase=0; start ignored in any other state.
REQ-018 PRST: cpu_rst=1 for exactly RST_CYCLES cycles, then -> RUN.
REQ-019 RUN: cycle counter increments; exits to CREQ on halt_sys=1 or counter = PHASE_CYCLES-1, whichever first; halt and expiry in the same cycle counts as halt.
REQ-020 RUN expiry without halt with REQUIRE_HALT=1 SHALL increment fail_count once.
REQ-021 CREQ: chk_idx = phase*NUM_CHECKS + k, rd_en=1, rd_addr=chk_addr for one cycle, chk_exp latched; -> CWAIT.
REQ-022 CWAIT: compare rd_data to latched expected; mismatch -> mismatch pulse, fail_count+1; k<NUM_CHECKS-1 -> CREQ with k+1, else -> NEXT.
REQ-023 fail_count SHALL saturate at 255.
REQ-024 first_fail_phase SHALL capture phase on the first failure of the sequence only.
REQ-025 NEXT: phase = NUM_PHASES-1 -> DONE, else phase+1, -> PRST; no wrap of phase.
REQ-026 DONE: done=1 for one cycle, -> IDLE; fail_count and first_fail_phase hold until next start.
REQ-027 busy=1 in every state except IDLE.
REQ-028 rd_en SHALL be asserted only in CREQ; cpu_rst=0 outside PRST.

Reset
REQ-029 rst SHALL force IDLE immediately and clear phase, counters, k, fail_count, first_fail_phase, busy, done, mismatch, rd_en.
REQ-030 cpu_rst SHALL be 1 while rst=1 and 0 after rst releases in IDLE.
REQ-031 rst mid-sequence SHALL abort with no done pulse; results cleared.

Structure
REQ-032 State enum test_seq_state_e SHALL live in types_pkg; uword used for data/address.
REQ-033 A sub-module phase_timer (loadable down-counter with expire flag) SHALL serve PRST and RUN timing.

Verification
REQ-034 NUM_PHASES=2, halt_sys never, matching memory -> each phase: cpu_rst 2 cycles, RUN 20 cycles; done after 2 phases, fail_count=0.
REQ-035 halt_sys asserted cycle 5 of RUN -> CREQ next cycle; timeout not counted with REQUIRE_HALT=1.
REQ-036 Phase 1 check 0 expects 16'h2BCD, memory returns 16'h2BCC -> one mismatch pulse, fail_count=1, first_fail_phase=1.
REQ-037 Every check mismatches over 200 checks -> fail_count=255, no wrap.
REQ-038 rst asserted in phase 3 RUN -> immediate IDLE, outputs zero, cpu_rst=1 during rst, no done.
REQ-039 start pulsed while busy -> ignored; sequence and phase unaffected.
